// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: one SEG_WIDTH-bit segment per stage,
// carry registered between stages, sum/carry/overflow aligned at the output.
module adder_pipe #(
  parameter int WIDTH     = 32,
  parameter int SEG_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cr,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG_WIDTH;

  generate
    if (WIDTH <= 0 || SEG_WIDTH <= 0 || (WIDTH % SEG_WIDTH) != 0) begin : g_bad_width
      $error("adder_pipe: WIDTH must be a positive multiple of SEG_WIDTH");
    end
  endgenerate

  // Handshake: a transfer happens on a rising edge when valid & ready are both
  // high; valid never waits for ready, and ready (= advance) is combinational
  // from out_valid/out_ready so the whole pipeline moves or holds as one.

  logic [WIDTH-1:0]   r_a   [STAGES];
  logic [WIDTH-1:0]   r_b   [STAGES];
  logic [WIDTH-1:0]   r_f   [STAGES];
  logic               r_c   [STAGES];
  logic               r_v   [STAGES];
  logic               r_ovf;

  logic [WIDTH-1:0]   w_a   [STAGES];
  logic [WIDTH-1:0]   w_b   [STAGES];
  logic [WIDTH-1:0]   w_f   [STAGES];
  logic               w_cin [STAGES];
  logic               w_c   [STAGES];
  logic               w_v   [STAGES];
  logic [SEG_WIDTH:0] w_seg [STAGES];
  logic               w_ovf;
  logic               w_adv;

  always_comb begin
    w_adv = ~r_v[STAGES-1] | out_ready;
    w_ovf = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      w_a[k]   = '0;
      w_b[k]   = '0;
      w_f[k]   = '0;
      w_cin[k] = 1'b0;
      w_c[k]   = 1'b0;
      w_v[k]   = 1'b0;
      w_seg[k] = '0;
    end

    // Stage 0 takes the operands straight from the ports; subtraction is a + ~b + 1.
    w_a[0]   = a;
    w_b[0]   = sub ? ~b : b;
    w_cin[0] = sub | ci;
    w_v[0]   = in_valid;

    for (int k = 1; k < STAGES; k++) begin
      w_a[k]   = r_a[k-1];
      w_b[k]   = r_b[k-1];
      w_f[k]   = r_f[k-1];
      w_cin[k] = r_c[k-1];
      w_v[k]   = r_v[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      w_seg[k] = {1'b0, w_a[k][k*SEG_WIDTH +: SEG_WIDTH]}
               + {1'b0, w_b[k][k*SEG_WIDTH +: SEG_WIDTH]}
               + {{SEG_WIDTH{1'b0}}, w_cin[k]};
      w_f[k][k*SEG_WIDTH +: SEG_WIDTH] = w_seg[k][SEG_WIDTH-1:0];
      w_c[k] = w_seg[k][SEG_WIDTH];
    end

    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    w_ovf = w_a[STAGES-1][WIDTH-1] ^ w_b[STAGES-1][WIDTH-1]
          ^ w_seg[STAGES-1][SEG_WIDTH-1] ^ w_seg[STAGES-1][SEG_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_f[k] <= '0;
        r_c[k] <= 1'b0;
        r_v[k] <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= w_a[k];
        r_b[k] <= w_b[k];
        r_f[k] <= w_f[k];
        r_c[k] <= w_c[k];
        r_v[k] <= w_v[k];
      end
      r_ovf <= w_ovf;
    end
  end

  assign in_ready  = w_adv;
  assign out_valid = r_v[STAGES-1];
  assign f         = r_f[STAGES-1];
  assign cr        = r_c[STAGES-1];
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: directed vector table, backpressure, mid-flight reset,
// random streaming against a signed/unsigned arithmetic model, width sweep.
module tb_adder_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default 32/16 instance
  logic        in_valid, in_ready, ci, sub, out_valid, out_ready, cr, ovf;
  logic [31:0] a, b, f;
  // 16/16 instance
  logic        s16_in_valid, s16_in_ready, s16_ci, s16_sub, s16_out_valid, s16_out_ready, s16_cr, s16_ovf;
  logic [15:0] s16_a, s16_b, s16_f;
  // 64/16 instance
  logic        s64_in_valid, s64_in_ready, s64_ci, s64_sub, s64_out_valid, s64_out_ready, s64_cr, s64_ovf;
  logic [63:0] s64_a, s64_b, s64_f;

  adder_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .cr(cr), .ovf(ovf)
  );

  adder_pipe #(.WIDTH(16), .SEG_WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(s16_in_valid), .in_ready(s16_in_ready),
    .a(s16_a), .b(s16_b), .ci(s16_ci), .sub(s16_sub), .out_valid(s16_out_valid),
    .out_ready(s16_out_ready), .f(s16_f), .cr(s16_cr), .ovf(s16_ovf)
  );

  adder_pipe #(.WIDTH(64), .SEG_WIDTH(16)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(s64_in_valid), .in_ready(s64_in_ready),
    .a(s64_a), .b(s64_b), .ci(s64_ci), .sub(s64_sub), .out_valid(s64_out_valid),
    .out_ready(s64_out_ready), .f(s64_f), .cr(s64_cr), .ovf(s64_ovf)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sub;
    logic [31:0] f;
    logic        cr;
    logic        ovf;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_out    = 0;
  bit          sb_on    = 1'b0;
  logic [33:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic, result packed as {cr, ovf, f}.
  function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mci, input logic msub);
    longint sa, sb, s, ua, ub, u;
    logic   c, o;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    ua = longint'(ma);
    ub = longint'(mb);
    if (msub) begin
      s = sa - sb;
      u = ua - ub;
      c = (ua >= ub);
    end else begin
      s = sa + sb + longint'(mci);
      u = ua + ub + longint'(mci);
      c = (u >= 64'sh1_0000_0000);
    end
    o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {c, o, u[31:0]};
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 4))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return $urandom & 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard: handshake signals are stable at the falling edge.
  always @(negedge clk) begin
    if (sb_on && rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected_output actual=%0h required=none", f);
        end else begin
          chk("sb_result", 64'({cr, ovf, f}), 64'(exp_q.pop_front()));
          n_out++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, ci, sub));
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic drive_txn(input logic [31:0] ta, input logic [31:0] tb,
                           input logic tci, input logic tsub);
    bit acc = 1'b0;
    int g   = 0;
    in_valid = 1'b1;
    a = ta; b = tb; ci = tci; sub = tsub;
    while (!acc && g < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      g++;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL drive_timeout actual=not_accepted required=accepted");
    end
    in_valid = 1'b0;
    a = $urandom; b = $urandom; ci = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain(input int limit);
    int g = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && g < limit) begin
      @(posedge clk);
      #1;
      g++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[9];
    int          lat;
    int          stale;
    bit          done;
    logic [31:0] held;

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
    s16_in_valid = 1'b0; s16_a = '0; s16_b = '0; s16_ci = 1'b0; s16_sub = 1'b0; s16_out_ready = 1'b1;
    s64_in_valid = 1'b0; s64_a = '0; s64_b = '0; s64_ci = 1'b0; s64_sub = 1'b0; s64_out_ready = 1'b1;

    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_f", 64'(f), 64'd0);
    chk("rst_flags", 64'({cr, ovf}), 64'd0);
    chk("rst_s16_out_valid", 64'(s16_out_valid), 64'd0);
    chk("rst_s64_out_valid", 64'(s64_out_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors: {a, b, ci, sub, f, cr, ovf}
    vecs[0] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
    vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7] = '{32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
    vecs[8] = '{32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};

    for (int i = 0; i < 9; i++) begin
      drive_txn(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub);
      wait_out(lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      chk($sformatf("vec%0d_f", i), 64'(f), 64'(vecs[i].f));
      chk($sformatf("vec%0d_cr", i), 64'(cr), 64'(vecs[i].cr));
      chk($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(vecs[i].ovf));
      @(posedge clk);
      #1;
    end

    // Backpressure: 4 back-to-back, out_ready low for 3 cycles once output appears.
    sb_on = 1'b1;
    n_out = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) drive_txn(rand_word(), rand_word(), 1'($urandom), 1'($urandom));
      end
      begin
        int g = 0;
        while (!out_valid && g < 20) begin
          @(posedge clk);
          #1;
          g++;
        end
        out_ready = 1'b0;
        held = f;
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready_low", 64'(in_ready), 64'd0);
          chk("bp_out_valid_held", 64'(out_valid), 64'd1);
          chk("bp_f_stable", 64'(f), 64'(held));
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain(50);
    chk("bp_result_count", 64'(n_out), 64'd4);
    chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Random streaming with random gaps and random backpressure.
    n_out = 0;
    done  = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          drive_txn(rand_word(), rand_word(), 1'($urandom), 1'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain(100);
    chk("rand_result_count", 64'(n_out), 64'd1000);
    chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);
    sb_on = 1'b0;

    // Reset with two transactions in flight.
    out_ready = 1'b1;
    drive_txn(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    drive_txn(32'h0123_4567, 32'h0000_0001, 1'b0, 1'b0);
    chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_f", 64'(f), 64'h3333_3333);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_f", 64'(f), 64'd0);
    chk("mid_rst_flags", 64'({cr, ovf}), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("post_rst_no_stale", 64'(stale), 64'd0);
    @(posedge clk);
    #1;
    drive_txn(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_out(lat);
    chk("post_rst_latency", 64'(lat), 64'd2);
    chk("post_rst_f", 64'(f), 64'h0001_0000);
    @(posedge clk);
    #1;

    // Width sweep: all-ones + 1 on the 16/16 and 64/16 instances.
    s16_in_valid = 1'b1; s16_a = 16'hFFFF; s16_b = 16'h0001;
    @(negedge clk);
    chk("s16_in_ready", 64'(s16_in_ready), 64'd1);
    @(posedge clk);
    #1 s16_in_valid = 1'b0;
    lat = 1;
    while (!s16_out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("s16_latency", 64'(lat), 64'd1);
    chk("s16_f", 64'(s16_f), 64'd0);
    chk("s16_cr", 64'(s16_cr), 64'd1);
    chk("s16_ovf", 64'(s16_ovf), 64'd0);
    @(posedge clk);
    #1;

    s64_in_valid = 1'b1; s64_a = 64'hFFFF_FFFF_FFFF_FFFF; s64_b = 64'h1;
    @(negedge clk);
    chk("s64_in_ready", 64'(s64_in_ready), 64'd1);
    @(posedge clk);
    #1 s64_in_valid = 1'b0;
    lat = 1;
    while (!s64_out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("s64_latency", 64'(lat), 64'd4);
    chk("s64_f", s64_f, 64'd0);
    chk("s64_cr", 64'(s64_cr), 64'd1);
    chk("s64_ovf", 64'(s64_ovf), 64'd0);
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Parametrised, pipelined successor to the fixed 16-bit combinational adder wrapper.
- Adds or subtracts two WIDTH-bit operands in SEG_WIDTH-bit segments, one segment per pipeline stage, with the carry registered between stages.
- Valid/ready handshakes on both sides so it can sit in streaming datapaths.
- Produces sum, carry-out and signed-overflow flags.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a positive multiple of SEG_WIDTH.
- SEG_WIDTH, 16, bits added per pipeline stage.
- STAGES = WIDTH/SEG_WIDTH is derived, not overridable. A non-multiple WIDTH is an elaboration error.

Ports:
- clk  input  1  clock; rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and controls are valid this cycle.
- in_ready  output  1  block accepts the transaction this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in; used only when sub=0.
- sub  input  1  0: f=a+b+ci; 1: f=a-b (a+~b+1).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- f  output  WIDTH  sum/difference.
- cr  output  1  carry out of MSB; for sub, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, out_valid, f, cr and ovf clear to 0 immediately. in_ready is 1 during and after reset. Any in-flight transactions are discarded, with no partial result emitted. Reset release is synchronised by the user.
- Transfers:
  - Input transfer occurs on a rising edge with in_valid & in_ready.
  - Output transfer occurs on a rising edge with out_valid & out_ready.
- Pipeline advance: advance = ~out_valid | out_ready. The whole pipeline moves together when advance=1. in_ready = advance, combinationally.
- Stall: when advance=0, every stage register, including f/cr/ovf and all valid bits, holds. The presented output stays stable until accepted.
- Bubbles: a stage whose valid bit is 0 is overwritten on advance. The implementation need not compact bubbles.
- Stage k (0..STAGES-1):
  - Adds segment k of a and b' (b' = sub ? ~b : b) plus the carry from stage k-1.
  - Stage 0 carry-in is sub ? 1 : ci.
  - Higher segments of a and b', and lower result segments already computed, are carried forward in stage registers.
- Latency: STAGES cycles from input transfer to out_valid=1 with an unstalled pipeline. Throughput is one result per cycle.
- Flags:
  - cr is the carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
  - Both are registered with the final stage and aligned with f.
- Arithmetic is modulo 2^WIDTH. No saturation.
- Simultaneous in_valid, out_valid and out_ready in one cycle: the output transfers and a new input enters stage 0 on the same edge. No loss, no duplication.
- STAGES=1 degenerates to a single registered adder with latency 1.
- in_valid=0 with out_ready=1 inserts a bubble; out_valid drops once the bubble reaches the output.
- a, b, ci and sub are sampled only on an input transfer. Values on other cycles are ignored.

Test Plan:
- Defaults (WIDTH=32, SEG=16), out_ready=1. Send a=0x0000FFFF, b=0x00000001, ci=0, sub=0 -> f=0x00010000, cr=0, ovf=0, out_valid high exactly 2 cycles after the transfer (cross-segment carry).
- Overflow. Send a=0x7FFFFFFF, b=1, sub=0 -> f=0x80000000, ovf=1, cr=0. Then send a=0xFFFFFFFF, b=1, ci=1 -> f=0x00000001, cr=1, ovf=0.
- Subtract. Send a=5, b=7, sub=1, ci=1 (ignored) -> f=0xFFFFFFFE, cr=0, ovf=0. Then send a=0x80000000, b=1, sub=1 -> f=0x7FFFFFFF, cr=1, ovf=1.
- Backpressure. Stream 4 back-to-back transactions with out_ready low for 3 cycles mid-stream -> in_ready falls while out_valid=1; f stays stable; all 4 results emerge in order with none dropped or duplicated. Check against a reference model over 1000 random transactions with random in_valid/out_ready.
- Reset mid-operation. Assert rst_n=0 asynchronously between edges while 2 transactions are in flight -> out_valid, f, cr and ovf go 0 immediately. After release, no stale result appears and the next transaction has normal latency.
- Parameter sweep. Check WIDTH=16/SEG=16 (latency 1) and WIDTH=64/SEG=16 (latency 4) with 0xFFFF...FF + 1 -> f=0, cr=1 at the expected cycle.
